// File: rtl/simon_pkg.sv
// Shared defaults and FSM state encoding for the SIMON request controller.
package simon_pkg;

  localparam int unsigned SimonDataW  = 128;
  localparam int unsigned SimonTmoCyc = 255;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StStart = 3'd2,
    StWait  = 3'd3,
    StResp  = 3'd4
  } state_e;

endpackage

// File: rtl/simon_tmo_cnt.sv
// Saturating wait-cycle counter; expired_o flags that TMO_CYC cycles have been counted.
module simon_tmo_cnt
  import simon_pkg::*;
#(
  parameter int unsigned TMO_CYC = SimonTmoCyc
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // Sized to hold TMO_CYC even when TMO_CYC is 0.
  localparam int unsigned CntW = $clog2(TMO_CYC + 2);

  logic [CntW-1:0] r_cnt;

  assign expired_o = (r_cnt == CntW'(TMO_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && !expired_o) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/simon_req_ctrl.sv
// Request/response wrapper around a SIMON core: latches a request, pulses start,
// waits for the core's valid edge (or a timeout) and holds the result for downstream.
module simon_req_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned DATA_W  = SimonDataW,
  parameter int unsigned TMO_CYC = SimonTmoCyc
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_encrypt_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic [DATA_W-1:0] req_key_i,
  output logic              core_encrypt_o,
  output logic              core_start_o,
  output logic [DATA_W-1:0] core_pt_o,
  output logic [DATA_W-1:0] core_k0_o,
  input  logic              core_valid_i,
  input  logic [DATA_W-1:0] core_ct_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o
);

  state_e            r_state;
  state_e            w_state_next;
  logic              r_valid_prev;
  logic              r_encrypt;
  logic [DATA_W-1:0] r_pt;
  logic [DATA_W-1:0] r_k0;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic              w_hs;
  logic              w_rise;
  logic              w_expired;
  logic              w_in_wait;

  assign req_ready_o    = (r_state == StIdle);
  assign core_start_o   = (r_state == StStart);
  assign rsp_valid_o    = (r_state == StResp);
  assign core_encrypt_o = r_encrypt;
  assign core_pt_o      = r_pt;
  assign core_k0_o      = r_k0;
  assign rsp_data_o     = r_rsp_data;
  assign rsp_err_o      = r_rsp_err;

  assign w_hs      = req_valid_i & req_ready_o;
  assign w_in_wait = (r_state == StWait);
  // A valid level left over from the previous operation never counts as completion.
  assign w_rise    = core_valid_i & ~r_valid_prev;

  simon_tmo_cnt #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (core_start_o),
    .en_i      (w_in_wait),
    .expired_o (w_expired)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_hs) w_state_next = StSetup;
      StSetup: w_state_next = StStart;
      StStart: w_state_next = StWait;
      StWait:  if (w_rise || w_expired) w_state_next = StResp;
      StResp:  if (rsp_ready_i) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_valid_prev <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_valid_prev <= core_valid_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_encrypt <= 1'b0;
      r_pt      <= '0;
      r_k0      <= '0;
    end else if (w_hs) begin
      r_encrypt <= req_encrypt_i;
      r_pt      <= req_data_i;
      r_k0      <= req_key_i;
    end
  end

  // Completion takes priority over a timeout landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else if (w_in_wait) begin
      if (w_rise) begin
        r_rsp_data <= core_ct_i;
        r_rsp_err  <= 1'b0;
      end else if (w_expired) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_simon_req_ctrl.sv
// Directed bench for simon_req_ctrl with a lookup-table SIMON core model (68-cycle latency).
module tb_simon_req_ctrl;

  localparam int unsigned DW = 128;
  localparam logic [DW-1:0] PT  = 128'h63736564207372656c6c657661727420;
  localparam logic [DW-1:0] KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [DW-1:0] CT  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_encrypt_i = 1'b0;
  logic [DW-1:0] req_data_i = '0;
  logic [DW-1:0] req_key_i = '0;
  logic          core_encrypt_o;
  logic          core_start_o;
  logic [DW-1:0] core_pt_o;
  logic [DW-1:0] core_k0_o;
  logic          core_valid_i = 1'b0;
  logic [DW-1:0] core_ct_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_err_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  simon_req_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_encrypt_i  (req_encrypt_i),
    .req_data_i     (req_data_i),
    .req_key_i      (req_key_i),
    .core_encrypt_o (core_encrypt_o),
    .core_start_o   (core_start_o),
    .core_pt_o      (core_pt_o),
    .core_k0_o      (core_k0_o),
    .core_valid_i   (core_valid_i),
    .core_ct_i      (core_ct_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_data_o     (rsp_data_o),
    .rsp_err_o      (rsp_err_o)
  );

  always #5 clk = ~clk;

  // Core model: known-answer lookup; valid stays high after completion and drops
  // three cycles into the next operation, so the controller sees a stale level first.
  logic          m_armed = 1'b0;
  logic          m_respond = 1'b1;
  int            m_cnt = 0;
  logic          m_enc = 1'b0;
  logic [DW-1:0] m_pt = '0;
  logic [DW-1:0] m_key = '0;

  function automatic logic [DW-1:0] core_fn(input logic enc, input logic [DW-1:0] d,
                                            input logic [DW-1:0] k);
    if (enc && d == PT && k == KEY) return CT;
    if (!enc && d == CT && k == KEY) return PT;
    return ~d;
  endfunction

  always @(negedge clk) begin
    if (core_start_o) begin
      m_armed = 1'b1;
      m_cnt   = 0;
      m_enc   = core_encrypt_o;
      m_pt    = core_pt_o;
      m_key   = core_k0_o;
    end else if (m_armed) begin
      m_cnt++;
      if (m_cnt == 3) core_valid_i = 1'b0;
      if (m_cnt == 68 && m_respond) begin
        core_valid_i = 1'b1;
        core_ct_i    = core_fn(m_enc, m_pt, m_key);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake in the current IDLE cycle (cycle 0); returns at cycle 3 (first WAIT cycle).
  task automatic start_req(input logic enc, input logic [DW-1:0] d, input logic [DW-1:0] k);
    req_valid_i   = 1'b1;
    req_encrypt_i = enc;
    req_data_i    = d;
    req_key_i     = k;
    vec_cnt++;
    if (req_ready_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL hs_ready: got %b want 1", req_ready_o);
    end
    tick();
    req_valid_i   = 1'b0;
    req_encrypt_i = ~enc;
    req_data_i    = '0;
    req_key_i     = '0;
    vec_cnt++;
    if (core_pt_o !== d || core_k0_o !== k || core_encrypt_o !== enc ||
        core_start_o !== 1'b0 || req_ready_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL setup: pt=%h k0=%h enc=%b start=%b rdy=%b want pt=%h k0=%h enc=%b start=0 rdy=0",
               core_pt_o, core_k0_o, core_encrypt_o, core_start_o, req_ready_o, d, k, enc);
    end
    tick();
    vec_cnt++;
    if (core_start_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL start_pulse: got %b want 1", core_start_o);
    end
    tick();
    vec_cnt++;
    if (core_start_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL start_width: got %b want 0", core_start_o);
    end
  endtask

  // Returns the cycle number (handshake = 0) at which rsp_valid_o is first seen.
  task automatic wait_rsp(input logic enc, input logic [DW-1:0] d, input logic [DW-1:0] k,
                          output int cyc);
    logic stable;
    stable = 1'b1;
    cyc    = 3;
    while (rsp_valid_o !== 1'b1 && cyc < 400) begin
      if (core_encrypt_o !== enc || core_pt_o !== d || core_k0_o !== k ||
          req_ready_o !== 1'b0 || core_start_o !== 1'b0) stable = 1'b0;
      tick();
      cyc++;
    end
    vec_cnt++;
    if (!stable) begin
      err_cnt++;
      $display("FAIL wait_stable: core outputs changed during WAIT (enc now %b want %b)",
               core_encrypt_o, enc);
    end
  endtask

  task automatic check_rsp(input string name, input int cyc, input int exp_cyc,
                           input logic [DW-1:0] exp_data, input logic exp_err);
    vec_cnt++;
    if (cyc != exp_cyc) begin
      err_cnt++;
      $display("FAIL %s_latency: got cycle %0d want %0d", name, cyc, exp_cyc);
    end
    vec_cnt++;
    if (rsp_data_o !== exp_data || rsp_err_o !== exp_err) begin
      err_cnt++;
      $display("FAIL %s_data: got %h err=%b want %h err=%b", name, rsp_data_o, rsp_err_o,
               exp_data, exp_err);
    end
  endtask

  task automatic consume();
    rsp_ready_i = 1'b1;
    vec_cnt++;
    if (req_ready_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL no_accept_on_consume: req_ready got %b want 0", req_ready_o);
    end
    tick();
    rsp_ready_i = 1'b0;
    vec_cnt++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL back_to_idle: rsp_valid=%b req_ready=%b want 0 1", rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    vec_cnt++;
    if ({req_ready_o, core_start_o, core_encrypt_o, rsp_valid_o, rsp_err_o} !== 5'b10000 ||
        core_pt_o !== '0 || core_k0_o !== '0 || rsp_data_o !== '0) begin
      err_cnt++;
      $display("FAIL %s: rdy/start/enc/vld/err=%b%b%b%b%b pt=%h k0=%h data=%h want 10000 and zeros",
               name, req_ready_o, core_start_o, core_encrypt_o, rsp_valid_o, rsp_err_o,
               core_pt_o, core_k0_o, rsp_data_o);
    end
  endtask

  task automatic test_reset();
    #2;
    check_zero_outputs("reset_state");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_zero_outputs("post_reset_idle");
  endtask

  task automatic test_encrypt();
    int cyc;
    start_req(1'b1, PT, KEY);
    wait_rsp(1'b1, PT, KEY, cyc);
    check_rsp("encrypt", cyc, 71, CT, 1'b0);
    consume();
  endtask

  task automatic test_decrypt();
    int cyc;
    start_req(1'b0, CT, KEY);
    wait_rsp(1'b0, CT, KEY, cyc);
    check_rsp("decrypt", cyc, 71, PT, 1'b0);
    consume();
  endtask

  task automatic test_timeout();
    int cyc;
    m_respond = 1'b0;
    start_req(1'b1, PT, KEY);
    wait_rsp(1'b1, PT, KEY, cyc);
    check_rsp("timeout", cyc, 259, '0, 1'b1);
    consume();
    m_respond = 1'b1;
  endtask

  task automatic test_back_to_back();
    int   cyc;
    logic ok;
    start_req(1'b1, PT, KEY);
    wait_rsp(1'b1, PT, KEY, cyc);
    check_rsp("stall", cyc, 71, CT, 1'b0);
    req_valid_i   = 1'b1;
    req_encrypt_i = 1'b0;
    req_data_i    = CT;
    req_key_i     = KEY;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== CT || rsp_err_o !== 1'b0 ||
          req_ready_o !== 1'b0) ok = 1'b0;
      tick();
    end
    vec_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL stall_hold: vld=%b data=%h err=%b rdy=%b want 1 %h 0 0",
               rsp_valid_o, rsp_data_o, rsp_err_o, req_ready_o, CT);
    end
    consume();
    start_req(1'b0, CT, KEY);
    wait_rsp(1'b0, CT, KEY, cyc);
    check_rsp("b2b", cyc, 71, PT, 1'b0);
    consume();
  endtask

  task automatic test_reset_mid();
    int   cyc;
    logic quiet;
    start_req(1'b1, PT, KEY);
    repeat (20) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_in_wait");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) quiet = 1'b0;
      tick();
    end
    vec_cnt++;
    if (!quiet) begin
      err_cnt++;
      $display("FAIL reset_no_rsp: vld=%b rdy=%b want 0 1", rsp_valid_o, req_ready_o);
    end
    start_req(1'b1, PT, KEY);
    wait_rsp(1'b1, PT, KEY, cyc);
    check_rsp("after_reset", cyc, 71, CT, 1'b0);
    consume();
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
